// File: rtl/hazard3_dmi_arbiter.sv
// Two-port APB arbiter in front of the Debug Module's DMI completer port.
// Round-robin grant between two requesters, whole-transfer locking, and an
// optional access-phase timeout that recovers from a hung Debug Module.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer; dst_* held at zero, waiting for a source psel
// SETUP  | downstream APB setup phase for the granted source
// ACCESS | downstream APB access phase; wait for pready or timeout

module hazard3_dmi_arbiter #(
    parameter int W_ADDR  = 8,
    parameter int W_DATA  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              src0_psel,
    input  logic              src0_penable,
    input  logic              src0_pwrite,
    input  logic [W_ADDR-1:0] src0_paddr,
    input  logic [W_DATA-1:0] src0_pwdata,
    output logic [W_DATA-1:0] src0_prdata,
    output logic              src0_pready,
    output logic              src0_pslverr,

    input  logic              src1_psel,
    input  logic              src1_penable,
    input  logic              src1_pwrite,
    input  logic [W_ADDR-1:0] src1_paddr,
    input  logic [W_DATA-1:0] src1_pwdata,
    output logic [W_DATA-1:0] src1_prdata,
    output logic              src1_pready,
    output logic              src1_pslverr,

    output logic              dst_psel,
    output logic              dst_penable,
    output logic              dst_pwrite,
    output logic [W_ADDR-1:0] dst_paddr,
    output logic [W_DATA-1:0] dst_pwdata,
    input  logic [W_DATA-1:0] dst_prdata,
    input  logic              dst_pready,
    input  logic              dst_pslverr,

    output logic              timeout_pulse
);

    localparam bit TO_EN = (TIMEOUT != 0);
    localparam int W_CNT = (TIMEOUT > 0 && $clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TO_EN ? TIMEOUT - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;

    logic             in_access;
    logic             timeout_hit;
    logic             complete;
    logic [W_DATA-1:0] rsp_data;
    logic             rsp_err;

    // Completion qualifiers shared by the FSM and the response path
    always_comb begin
        in_access   = (state_q == S_ACCESS);
        timeout_hit = TO_EN && in_access && !dst_pready && (cnt_q == CNT_LAST);
        complete    = in_access && (dst_pready || timeout_hit);
        rsp_data    = timeout_hit ? '0 : dst_prdata;
        rsp_err     = timeout_hit | dst_pslverr;
    end

    // Next-state: grant selection, phase sequencing, timeout counter
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (src0_psel || src1_psel) begin
                    // On contention the port that did not go last wins
                    grant_d = (src0_psel && src1_psel) ? ~last_grant_q : src1_psel;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (complete) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to 1 so port 0 wins the first contest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Downstream request mux; everything zero while idle so nothing leaks
    always_comb begin
        dst_psel    = 1'b0;
        dst_penable = 1'b0;
        dst_pwrite  = 1'b0;
        dst_paddr   = '0;
        dst_pwdata  = '0;
        if (state_q != S_IDLE) begin
            dst_psel    = 1'b1;
            dst_penable = in_access;
            dst_pwrite  = grant_q ? src1_pwrite : src0_pwrite;
            dst_paddr   = grant_q ? src1_paddr  : src0_paddr;
            dst_pwdata  = grant_q ? src1_pwdata : src0_pwdata;
        end
    end

    // Upstream response routing; a source that abandoned its request gets nothing
    always_comb begin
        src0_pready   = 1'b0;
        src0_pslverr  = 1'b0;
        src0_prdata   = '0;
        src1_pready   = 1'b0;
        src1_pslverr  = 1'b0;
        src1_prdata   = '0;
        timeout_pulse = timeout_hit;
        if (complete && !grant_q && src0_psel) begin
            src0_pready  = 1'b1;
            src0_pslverr = rsp_err;
            src0_prdata  = rsp_data;
        end
        if (complete && grant_q && src1_psel) begin
            src1_pready  = 1'b1;
            src1_pslverr = rsp_err;
            src1_prdata  = rsp_data;
        end
    end

    // penable is deliberately not used: a source already in its access phase is accepted
    logic unused_penable;
    always_comb unused_penable = src0_penable ^ src1_penable;

endmodule
